// File: rtl/lane_draw_pkg.sv
// Shared types and defaults for the lane-based character display draw engines.
package lane_draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } draw_state_e;

  localparam logic MODE_ERASE = 1'b0;
  localparam logic MODE_PAINT = 1'b1;

  // Lane left edges, lane 0 in the LSBs.
  localparam logic [31:0] DEFAULT_POS_X = {8'd132, 8'd78, 8'd24, 8'd6};
  localparam int unsigned DEFAULT_ROW_Y = 102;

  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_rect_painter_if.sv
// Request/pixel-stream bundle between the game control FSM and the rectangle painter.
interface lane_rect_painter_if #(
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned SEL_W   = 2
);
  logic               Start;
  logic [SEL_W-1:0]   PosSel;
  logic               Mode;
  logic [COLOR_W-1:0] DrawColor;
  logic               Busy;
  logic [X_W-1:0]     XOut;
  logic [Y_W-1:0]     YOut;
  logic [COLOR_W-1:0] ColorOut;
  logic               Plot;
  logic               Done;

  modport master (
    output Start, PosSel, Mode, DrawColor,
    input  Busy, XOut, YOut, ColorOut, Plot, Done
  );

  modport slave (
    input  Start, PosSel, Mode, DrawColor,
    output Busy, XOut, YOut, ColorOut, Plot, Done
  );
endinterface

// File: rtl/rect_scan_counter.sv
// Raster-order (xc, yc) counter over a RECT_W x RECT_H block.
// xc/yc are the count the counter takes at the next edge, so callers can register pixels in step.
module rect_scan_counter
  import lane_draw_pkg::*;
#(
  parameter int unsigned RECT_W = 9,
  parameter int unsigned RECT_H = 5,
  localparam int unsigned XC_W  = idx_width(RECT_W),
  localparam int unsigned YC_W  = idx_width(RECT_H)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            clear,
  input  logic            step,
  output logic [XC_W-1:0] xc,
  output logic [YC_W-1:0] yc,
  output logic            last
);

  localparam logic [XC_W-1:0] XMax = XC_W'(RECT_W - 1);
  localparam logic [YC_W-1:0] YMax = YC_W'(RECT_H - 1);

  logic [XC_W-1:0] xc_q, xc_d;
  logic [YC_W-1:0] yc_q, yc_d;

  assign last = (xc_q == XMax) && (yc_q == YMax);

  always_comb begin
    xc_d = xc_q;
    yc_d = yc_q;
    if (clear) begin
      xc_d = '0;
      yc_d = '0;
    end else if (step) begin
      if (xc_q == XMax) begin
        xc_d = '0;
        yc_d = (yc_q == YMax) ? '0 : yc_q + 1'b1;
      end else begin
        xc_d = xc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      xc_q <= '0;
      yc_q <= '0;
    end else begin
      xc_q <= xc_d;
      yc_q <= yc_d;
    end
  end

  assign xc = xc_d;
  assign yc = yc_d;

endmodule

// File: rtl/lane_rect_painter.sv
// Fills one lane's character cell with the background or a caller colour, one pixel per clock,
// streaming X/Y/colour/Plot to the VGA adapter and pulsing Done at the end.
module lane_rect_painter
  import lane_draw_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned RECT_W   = 9,
  parameter int unsigned RECT_H   = 5,
  parameter int unsigned NUM_POS  = 4,
  parameter logic [NUM_POS*X_W-1:0] POS_X = (NUM_POS*X_W)'(DEFAULT_POS_X),
  parameter int unsigned ROW_Y    = DEFAULT_ROW_Y,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter logic [COLOR_W-1:0] BG_COLOR = '1
) (
  input logic Clock,
  input logic Reset,
  lane_rect_painter_if.slave bus
);

  localparam int unsigned SEL_W = idx_width(NUM_POS);
  localparam int unsigned XC_W  = idx_width(RECT_W);
  localparam int unsigned YC_W  = idx_width(RECT_H);

  draw_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic               mode_q, mode_n;
  logic [COLOR_W-1:0] draw_q, draw_n, color_n;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] c_q;
  logic               plot_q, plot_d;
  logic               accept, scan_last;
  logic [XC_W-1:0]    xc_n;
  logic [YC_W-1:0]    yc_n;
  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return {1'b0, s} < (SEL_W + 1)'(NUM_POS);
  endfunction

  function automatic logic [X_W-1:0] lane_x(input logic [SEL_W-1:0] s);
    logic [X_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_POS); i++) begin
      if (SEL_W'(i) == s) r = POS_X[i*X_W +: X_W];
    end
    return r;
  endfunction

  assign accept = (state_q == IDLE) && bus.Start;

  rect_scan_counter #(
    .RECT_W (RECT_W),
    .RECT_H (RECT_H)
  ) u_counter (
    .Clock (Clock),
    .Reset (Reset),
    .clear (accept),
    .step  (state_q == SCAN),
    .xc    (xc_n),
    .yc    (yc_n),
    .last  (scan_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = SCAN;
      // An out-of-range lane spends a single blank SCAN cycle.
      SCAN:    if (!sel_ok(sel_q) || scan_last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel registered now is the one presented during the next cycle.
  always_comb begin
    sel_n   = accept ? bus.PosSel    : sel_q;
    mode_n  = accept ? bus.Mode      : mode_q;
    draw_n  = accept ? bus.DrawColor : draw_q;
    color_n = (mode_n == MODE_PAINT) ? draw_n : BG_COLOR;
    x_sum   = {1'b0, lane_x(sel_n)} + (X_W + 1)'(xc_n);
    y_sum   = (Y_W + 1)'(ROW_Y) + (Y_W + 1)'(yc_n);
    plot_d  = (state_d == SCAN) && sel_ok(sel_n) &&
              (x_sum < (X_W + 1)'(SCREEN_W)) && (y_sum < (Y_W + 1)'(SCREEN_H));
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      draw_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plot_q  <= plot_d;
      if (accept) begin
        sel_q  <= bus.PosSel;
        mode_q <= bus.Mode;
        draw_q <= bus.DrawColor;
      end
      if (state_d == SCAN) begin
        x_q <= x_sum[X_W-1:0];
        y_q <= y_sum[Y_W-1:0];
        c_q <= color_n;
      end
    end
  end

  assign bus.Busy     = (state_q != IDLE);
  assign bus.Done     = (state_q == FIN);
  assign bus.Plot     = plot_q;
  assign bus.XOut     = x_q;
  assign bus.YOut     = y_q;
  assign bus.ColorOut = c_q;

endmodule

// File: tb/tb_lane_rect_painter.sv
// Self-checking bench: directed and random fill jobs against a per-pixel list model.
module tb_lane_rect_painter;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  lane_rect_painter_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .SEL_W(2)) bus_a ();
  lane_rect_painter_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .SEL_W(2)) bus_b ();

  lane_rect_painter dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  lane_rect_painter #(
    .RECT_W  (30),
    .NUM_POS (3),
    .POS_X   ({8'd100, 8'd40, 8'd150})
  ) dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  typedef struct {
    int x;
    int y;
    bit plot;
  } px_t;

  int lanes_a[4] = '{6, 24, 78, 132};
  int lanes_b[3] = '{150, 40, 100};

  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_c;
  logic       o_plot, o_busy, o_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit w);
    if (w) begin
      o_x = bus_b.XOut; o_y = bus_b.YOut; o_c = bus_b.ColorOut;
      o_plot = bus_b.Plot; o_busy = bus_b.Busy; o_done = bus_b.Done;
    end else begin
      o_x = bus_a.XOut; o_y = bus_a.YOut; o_c = bus_a.ColorOut;
      o_plot = bus_a.Plot; o_busy = bus_a.Busy; o_done = bus_a.Done;
    end
  endtask

  task automatic drive(input bit w, input logic st, input int sel, input bit mode, input int color);
    if (w) begin
      bus_b.Start = st; bus_b.PosSel = 2'(sel); bus_b.Mode = mode; bus_b.DrawColor = 3'(color);
    end else begin
      bus_a.Start = st; bus_a.PosSel = 2'(sel); bus_a.Mode = mode; bus_a.DrawColor = 3'(color);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // One job from the Start cycle through the first IDLE cycle after Done.
  task automatic do_job(input bit w, input int sel, input bit mode, input int color,
                        input int glitch_at, input int abort_at, input bit fin_start);
    px_t q[$];
    px_t p;
    int  width, npos, lane, nplot, seen, c_exp;
    width = w ? 30 : 9;
    npos  = w ? 3 : 4;
    nplot = 0;
    seen  = 0;
    lane  = 0;
    c_exp = mode ? color : 7;
    if (sel >= npos) begin
      p.x = 0; p.y = 0; p.plot = 1'b0;
      q.push_back(p);
    end else begin
      lane = w ? lanes_b[sel] : lanes_a[sel];
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < width; x++) begin
          p.x = lane + x;
          p.y = 102 + y;
          p.plot = (p.x < 160) && (p.y < 120);
          if (p.plot) nplot++;
          q.push_back(p);
        end
      end
    end

    drive(w, 1'b1, sel, mode, color);
    tick;
    // Scramble request inputs to show they were latched.
    drive(w, 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 7));

    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        Reset = 1'b0;
        tick;
        Reset = 1'b1;
        sample(w);
        check("abort_plot", 32'(o_plot), 0);
        check("abort_busy", 32'(o_busy), 0);
        check("abort_done", 32'(o_done), 0);
        return;
      end
      sample(w);
      check("scan_busy", 32'(o_busy), 1);
      check("scan_done", 32'(o_done), 0);
      check("scan_plot", 32'(o_plot), 32'(q[i].plot));
      if (o_plot) seen++;
      if (q[i].plot) begin
        check("pix_x", 32'(o_x), 32'(q[i].x & 255));
        check("pix_y", 32'(o_y), 32'(q[i].y & 127));
        check("pix_color", 32'(o_c), 32'(c_exp));
      end
      if (i == glitch_at) drive(w, 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
      tick;
      if (i == glitch_at) drive(w, 1'b0, 0, 1'b0, 0);
    end

    sample(w);
    check("fin_done", 32'(o_done), 1);
    check("fin_busy", 32'(o_busy), 1);
    check("fin_plot", 32'(o_plot), 0);
    check("plot_count", 32'(seen), 32'(nplot));
    if (fin_start) drive(w, 1'b1, $urandom_range(0, 3), 1'b0, 0);
    tick;
    drive(w, 1'b0, 0, 1'b0, 0);
    sample(w);
    check("idle_busy", 32'(o_busy), 0);
    check("idle_done", 32'(o_done), 0);
    check("idle_plot", 32'(o_plot), 0);
    if (sel < npos) check("hold_x", 32'(o_x), 32'((lane + width - 1) & 255));
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 1'b0, 0);
    drive(1'b1, 1'b0, 0, 1'b0, 0);
    Reset = 1'b0;
    tick;
    tick;
    for (int w = 0; w < 2; w++) begin
      sample(1'(w));
      check("rst_x", 32'(o_x), 0);
      check("rst_y", 32'(o_y), 0);
      check("rst_color", 32'(o_c), 0);
      check("rst_plot", 32'(o_plot), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_done", 32'(o_done), 0);
    end
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      sample(1'b0);
      check("idle_noplot", 32'(o_plot), 0);
      check("idle_nobusy", 32'(o_busy), 0);
    end

    // Erase lane 2: caller colour must be ignored.
    do_job(1'b0, 2, 1'b0, 5, -1, -1, 1'b0);
    // Paint lane 3 with a mid-job Start and Start held in the FIN cycle.
    do_job(1'b0, 3, 1'b1, 4, 10, -1, 1'b1);
    // Abort at pixel 20, then a fresh job from (0,0), back-to-back with the next.
    do_job(1'b0, 1, 1'b1, 2, -1, 20, 1'b0);
    do_job(1'b0, 1, 1'b1, 2, -1, -1, 1'b0);
    do_job(1'b0, 0, 1'b1, 6, -1, -1, 1'b0);
    // Wide cell partly off the right edge.
    do_job(1'b1, 0, 1'b1, 3, -1, -1, 1'b0);
    // Out-of-range lane on the three-lane instance.
    do_job(1'b1, 3, 1'b1, 3, -1, -1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      do_job(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7), ($urandom_range(0, 1) != 0) ? $urandom_range(0, 20) : -1,
             -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
